// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the register-file/ALU datapath (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK).
// Optional feature: define ILLEGAL_TRAP_EN to trap on unknown opcodes; otherwise they retire as NOPs.
module multicycle_ctrl #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int ALUCTRL_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              instr,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic                     EQ,
  input  logic                     mem_done,
  output logic [ADDRESS_WIDTH-1:0] rs1,
  output logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [ADDRESS_WIDTH-1:0] rd,
  output logic                     ALUsrc,
  output logic [ALUCTRL_WIDTH-1:0] ALUctrl,
  output logic [2:0]               ImmSrc,
  output logic                     RegWrite,
  output logic                     WriteNextPC,
  output logic                     MemRead,
  output logic                     MemWrite,
  output logic                     ResultSrc,
  output logic [1:0]               PCsrc,
  output logic                     PCwrite,
  output logic                     illegal
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LUI, C_JAL, C_JALR, C_LOAD, C_STORE, C_BRANCH, C_NOP
  } iclass_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  state_t      state_q, state_d;
  logic [31:0] instr_q;
  iclass_t     cls_q, cls_d;
  logic        alusrc_q, alusrc_d;
  logic [2:0]  aluop_q, aluop_d;
  logic [2:0]  immsrc_q, immsrc_d;
  logic        resultsrc_q, resultsrc_d;

  wire [6:0] opcode   = instr_q[6:0];
  wire [2:0] funct3   = instr_q[14:12];
  wire       funct7b5 = instr_q[30];
  wire       rd_nz    = (instr_q[11:7] != 5'd0);

  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_q[31], instr_q[29:25]};

  // Only ADD/SUB is split by funct7; shifts and SLTU fall back to ADD.
  function automatic logic [2:0] alu_from_funct3(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_from_funct3 = sub ? ALU_SUB : ALU_ADD;
      3'b010:  alu_from_funct3 = ALU_SLT;
      3'b100:  alu_from_funct3 = ALU_XOR;
      3'b110:  alu_from_funct3 = ALU_OR;
      3'b111:  alu_from_funct3 = ALU_AND;
      default: alu_from_funct3 = ALU_ADD;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cls_d       = C_NOP;
    alusrc_d    = 1'b0;
    aluop_d     = ALU_ADD;
    immsrc_d    = IMM_I;
    resultsrc_d = 1'b0;
    case (opcode)
      OP_R: begin
        cls_d   = C_ALU;
        aluop_d = alu_from_funct3(funct3, funct7b5);
      end
      OP_I: begin
        cls_d    = C_ALU;
        alusrc_d = 1'b1;
        aluop_d  = alu_from_funct3(funct3, 1'b0);
      end
      OP_LOAD: begin
        cls_d       = C_LOAD;
        alusrc_d    = 1'b1;
        resultsrc_d = 1'b1;
      end
      OP_STORE: begin
        cls_d    = C_STORE;
        alusrc_d = 1'b1;
        immsrc_d = IMM_S;
      end
      OP_BRANCH: begin
        cls_d    = C_BRANCH;
        aluop_d  = ALU_SUB;
        immsrc_d = IMM_B;
      end
      OP_LUI: begin
        cls_d    = C_LUI;
        alusrc_d = 1'b1;
        immsrc_d = IMM_U;
      end
      OP_JAL: begin
        cls_d    = C_JAL;
        immsrc_d = IMM_J;
      end
      OP_JALR: begin
        cls_d    = C_JALR;
        alusrc_d = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      instr_q     <= '0;
      cls_q       <= C_NOP;
      alusrc_q    <= 1'b0;
      aluop_q     <= ALU_ADD;
      immsrc_q    <= IMM_I;
      resultsrc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && instr_valid)
        instr_q <= instr;
      if (state_q == S_DECODE) begin
        cls_q       <= cls_d;
        alusrc_q    <= alusrc_d;
        aluop_q     <= aluop_d;
        immsrc_q    <= immsrc_d;
        resultsrc_q <= resultsrc_d;
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (rst)
      illegal_q <= 1'b0;
    else if (state_q == S_DECODE && cls_d == C_NOP)
      illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    RegWrite    = 1'b0;
    WriteNextPC = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    PCsrc       = 2'b00;
    PCwrite     = 1'b0;
    case (state_q)
      S_FETCH: begin
        // Held low while reset is asserted, even though the state is already FETCH.
        instr_ready = !rst;
        if (instr_valid && !rst)
          state_d = S_DECODE;
      end
      S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = (cls_d == C_NOP) ? S_TRAP : S_EXECUTE;
`else
        state_d = S_EXECUTE;
`endif
      end
      S_EXECUTE: begin
        case (cls_q)
          C_LOAD, C_STORE: state_d = S_MEMORY;
          C_BRANCH: begin
            // funct3[0] distinguishes BNE from BEQ, so it inverts the taken sense.
            PCsrc   = {1'b0, EQ ^ instr_q[12]};
            PCwrite = 1'b1;
            state_d = S_FETCH;
          end
          C_NOP: begin
            PCwrite = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_WRITEBACK;
        endcase
      end
      S_MEMORY: begin
        MemRead  = (cls_q == C_LOAD);
        MemWrite = (cls_q == C_STORE);
        if (mem_done) begin
          if (cls_q == C_LOAD) begin
            state_d = S_WRITEBACK;
          end else begin
            PCwrite = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        RegWrite    = rd_nz;
        PCwrite     = 1'b1;
        WriteNextPC = (cls_q == C_JAL) || (cls_q == C_JALR);
        if (cls_q == C_JAL)
          PCsrc = 2'b01;
        else if (cls_q == C_JALR)
          PCsrc = 2'b10;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  assign rs1       = ADDRESS_WIDTH'(instr_q[19:15]);
  assign rs2       = ADDRESS_WIDTH'(instr_q[24:20]);
  assign rd        = ADDRESS_WIDTH'(instr_q[11:7]);
  assign ALUsrc    = alusrc_q;
  assign ALUctrl   = ALUCTRL_WIDTH'(aluop_q);
  assign ImmSrc    = immsrc_q;
  assign ResultSrc = resultsrc_q;

endmodule
